// File: rtl/triangle_receiver.sv
// -----------------------------------------------------------------------------
// triangle_receiver
//
// Consumer end of the mesh vertex fetcher's triangle stream. Each pulse on
// valid_in delivers a whole triangle (three homogeneous vertices plus an
// end-of-object flag). Triangles are buffered in a small FIFO and re-emitted
// one vertex per handshake on a valid/ready stream for the transform and
// projection stages.
//
// ready_out is asserted while at least two slots are free. The fetcher keeps
// at most one triangle in flight, so under protocol the FIFO never overflows.
//
// Parameters
//   DEPTH       FIFO depth in triangles (power of two, >= 2)
//   NUM_FACETS  expected triangles per object (used by the count check)
//
// Optional feature macro
//   TRIANGLE_RECEIVER_CHECK_EN  when defined, overflow_err and count_err are
//                               live sticky flags; otherwise both are tied 0.
//
// Ports
//   clk_in          system clock
//   rst_in          asynchronous, active-high reset
//   v1_in..v3_in    vertex words, [3]=x [2]=y [1]=z [0]=w
//   valid_in        one-cycle pulse, triangle present this cycle
//   obj_done_in     sampled with valid_in, last triangle of the object
//   ready_out       producer may launch one triangle the cycle after seeing 1
//   vertex_out      current vertex (0 while no vertex is valid)
//   vertex_idx_out  0/1/2 = v1/v2/v3 of the head triangle
//   last_out        vertex 2 of a triangle flagged obj_done
//   valid_out       vertex_out is valid
//   ready_in        downstream accepts the vertex when high with valid_out
//   tri_count_out   triangles accepted in the current object (saturating)
//   overflow_err    sticky: push attempted while the FIFO was full
//   count_err       sticky: object closed with a triangle count != NUM_FACETS
// -----------------------------------------------------------------------------
module triangle_receiver #(
  parameter int DEPTH      = 4,
  parameter int NUM_FACETS = 12
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [3:0][31:0] v1_in,
  input  logic [3:0][31:0] v2_in,
  input  logic [3:0][31:0] v3_in,
  input  logic             valid_in,
  input  logic             obj_done_in,
  output logic             ready_out,
  output logic [3:0][31:0] vertex_out,
  output logic [1:0]       vertex_idx_out,
  output logic             last_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [11:0]      tri_count_out,
  output logic             overflow_err,
  output logic             count_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);
  localparam logic [11:0]      TRI_MAX   = 12'hFFF;

  // Reject illegal configurations at elaboration time.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || NUM_FACETS < 1) begin : g_bad_params
    $error("triangle_receiver: DEPTH must be a power of two >= 2, NUM_FACETS >= 1");
  end

  typedef struct packed {
    logic [3:0][31:0] v1;
    logic [3:0][31:0] v2;
    logic [3:0][31:0] v3;
    logic             obj_done;
  } entry_t;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_EMIT  = 1'b1
  } state_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  entry_t           wr_entry;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  state_t           state;
  state_t           state_next;
  logic [1:0]       idx;
  logic [1:0]       idx_next;
  logic             push;
  logic             pop;
  logic [11:0]      tri_count;
  logic [3:0][31:0] head_word;

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  // A push while full is dropped silently; the flag below records it.
  assign push      = valid_in && (count < FULL_CNT);
  assign pop       = (state == S_EMIT) && ready_in && (idx == 2'd2);
  assign ready_out = (count <= READY_MAX);
  assign head      = mem[rptr];
  assign wr_entry  = '{v1: v1_in, v2: v2_in, v3: v3_in, obj_done: obj_done_in};

  // Pushes are blocked at count == DEPTH, so a simultaneous push and pop can
  // only happen with at least one free slot: the written slot is never the head.
  always_comb begin
    unique case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count_next;
    end
  end

  // NOTE: the triangle storage has no reset; pointers and count define which
  // entries are live, so stale contents are never observed.
  always_ff @(posedge clk_in) begin
    if (push) mem[wptr] <= wr_entry;
  end

  // ---------------------------------------------------------------------------
  // Per-object triangle counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tri_count <= '0;
    end else if (push) begin
      if (obj_done_in)            tri_count <= '0;
      else if (tri_count != TRI_MAX) tri_count <= tri_count + 1'b1;
    end
  end

  assign tri_count_out = tri_count;

  // ---------------------------------------------------------------------------
  // Serializer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= S_EMPTY;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Transitions look at count_next so a triangle pushed into an empty FIFO is
  // presented in the very next cycle, and a pop that leaves another triangle
  // buffered continues without a bubble.
  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch
    // is inferred.
    state_next = state;
    idx_next   = idx;
    unique case (state)
      S_EMPTY: begin
        if (count_next != '0) state_next = S_EMIT;
      end
      S_EMIT: begin
        if (ready_in) begin
          if (idx == 2'd2) begin
            idx_next = 2'd0;
            if (count_next == '0) state_next = S_EMPTY;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      default: state_next = S_EMPTY;
    endcase
  end

  always_comb begin
    unique case (idx)
      2'd1:    head_word = head.v2;
      2'd2:    head_word = head.v3;
      default: head_word = head.v1;
    endcase
  end

  // Outputs are forced to zero while empty so the head slot's stale contents
  // never appear on the bus.
  assign valid_out      = (state == S_EMIT);
  assign vertex_out     = valid_out ? head_word : '0;
  assign vertex_idx_out = idx;
  assign last_out       = valid_out && (idx == 2'd2) && head.obj_done;

  // ---------------------------------------------------------------------------
  // Optional protocol checks
  // ---------------------------------------------------------------------------
`ifdef TRIANGLE_RECEIVER_CHECK_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      overflow_err <= 1'b0;
      count_err    <= 1'b0;
    end else begin
      if (valid_in && (count == FULL_CNT)) overflow_err <= 1'b1;
      // Compare in 13 bits so a saturated count cannot alias NUM_FACETS.
      if (push && obj_done_in &&
          (({1'b0, tri_count} + 13'd1) != 13'(NUM_FACETS)))
        count_err <= 1'b1;
    end
  end
`else
  assign overflow_err = 1'b0;
  assign count_err    = 1'b0;
`endif

endmodule

// File: tb/tb_triangle_receiver.sv
// -----------------------------------------------------------------------------
// tb_triangle_receiver
//
// Directed stimulus with a scoreboard: each accepted triangle pushes its three
// expected vertices (value, index, last flag) into a queue, and an independent
// monitor pops and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_triangle_receiver;

  localparam int DEPTH      = 4;
  localparam int NUM_FACETS = 12;

`ifdef TRIANGLE_RECEIVER_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b0;
  logic [3:0][31:0] v1_in, v2_in, v3_in;
  logic             valid_in, obj_done_in;
  logic             ready_out;
  logic [3:0][31:0] vertex_out;
  logic [1:0]       vertex_idx_out;
  logic             last_out, valid_out;
  logic             ready_in;
  logic [11:0]      tri_count_out;
  logic             overflow_err, count_err;

  triangle_receiver #(.DEPTH(DEPTH), .NUM_FACETS(NUM_FACETS)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .v1_in         (v1_in),
    .v2_in         (v2_in),
    .v3_in         (v3_in),
    .valid_in      (valid_in),
    .obj_done_in   (obj_done_in),
    .ready_out     (ready_out),
    .vertex_out    (vertex_out),
    .vertex_idx_out(vertex_idx_out),
    .last_out      (last_out),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .tri_count_out (tri_count_out),
    .overflow_err  (overflow_err),
    .count_err     (count_err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [3:0][31:0] v;
    logic [1:0]       idx;
    logic             last;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0][31:0] mkv(input int x, input int y, input int z, input int w);
    return {32'(x), 32'(y), 32'(z), 32'(w)};
  endfunction

  // Distinct vertex j (0..2) of test triangle t.
  function automatic logic [3:0][31:0] tv(input int t, input int j);
    return mkv(t * 100 + j * 10 + 1, t * 100 + j * 10 + 2, t * 100 + j * 10 + 3, 1);
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_tri(input logic [3:0][31:0] a, input logic [3:0][31:0] b,
                          input logic [3:0][31:0] c, input logic od, input bit expect_ok);
    v1_in       = a;
    v2_in       = b;
    v3_in       = c;
    obj_done_in = od;
    valid_in    = 1'b1;
    if (expect_ok) begin
      sb.push_back(exp_t'{v: a, idx: 2'd0, last: 1'b0});
      sb.push_back(exp_t'{v: b, idx: 2'd1, last: 1'b0});
      sb.push_back(exp_t'{v: c, idx: 2'd2, last: od});
    end
    step();
    valid_in    = 1'b0;
    obj_done_in = 1'b0;
  endtask

  task automatic send_t(input int t, input logic od, input bit expect_ok);
    send_tri(tv(t, 0), tv(t, 1), tv(t, 2), od, expect_ok);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || valid_out) && n < budget) begin
      step();
      n++;
    end
    check("drain_queue_empty", 128'(sb.size()), 128'(0));
    check("drain_valid_low", 128'(valid_out), 128'(0));
  endtask

  task automatic do_reset();
    rst_in   = 1'b1;
    valid_in = 1'b0;
    repeat (2) step();
    sb.delete();
    rst_in = 1'b0;
    step();
  endtask

  // Monitor: compare every output handshake against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (rst_in === 1'b0 && valid_out === 1'b1 && ready_in === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_vertex got=%0h expected=none @%0t", vertex_out, $time);
        end else begin
          e = sb.pop_front();
          check("vertex", vertex_out, e.v);
          check("vertex_idx", 128'(vertex_idx_out), 128'(e.idx));
          check("last", 128'(last_out), 128'(e.last));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    v1_in = '0; v2_in = '0; v3_in = '0;
    valid_in = 1'b0; obj_done_in = 1'b0; ready_in = 1'b1;
    #1 rst_in = 1'b1;
    repeat (3) step();

    // Reset values, checked while reset is still held and after release.
    check("rst_ready_out", 128'(ready_out), 128'(1));
    check("rst_valid_out", 128'(valid_out), 128'(0));
    rst_in = 1'b0;
    step();
    check("rst_vertex_idx", 128'(vertex_idx_out), 128'(0));
    check("rst_last", 128'(last_out), 128'(0));
    check("rst_vertex", vertex_out, 128'(0));
    check("rst_tri_count", 128'(tri_count_out), 128'(0));
    check("rst_overflow_err", 128'(overflow_err), 128'(0));
    check("rst_count_err", 128'(count_err), 128'(0));

    // Single triangle: v1 in the cycle after acceptance, then v2, v3 back to back.
    send_tri(mkv(1, 2, 3, 1), mkv(4, 5, 6, 1), mkv(7, 8, 9, 1), 1'b0, 1'b1);
    check("lat_valid", 128'(valid_out), 128'(1));
    check("lat_idx0", 128'(vertex_idx_out), 128'(0));
    check("lat_v1", vertex_out, mkv(1, 2, 3, 1));
    step();
    check("seq_idx1", 128'(vertex_idx_out), 128'(1));
    check("seq_v2", vertex_out, mkv(4, 5, 6, 1));
    step();
    check("seq_idx2", 128'(vertex_idx_out), 128'(2));
    check("seq_v3", vertex_out, mkv(7, 8, 9, 1));
    check("seq_last0", 128'(last_out), 128'(0));
    step();
    check("single_done_valid", 128'(valid_out), 128'(0));
    check("single_tri_count", 128'(tri_count_out), 128'(1));
    wait_drain(10);

    // Twelve triangles at a 9-cycle cadence, object closed on the 12th.
    do_reset();
    for (int t = 0; t < NUM_FACETS; t++) begin
      send_t(t, (t == NUM_FACETS - 1), 1'b1);
      if (t == NUM_FACETS - 2) check("obj_tri_count_11", 128'(tri_count_out), 128'(11));
      repeat (8) step();
    end
    wait_drain(20);
    check("obj_tri_count_zero", 128'(tri_count_out), 128'(0));
    check("obj_count_err", 128'(count_err), 128'(0));

    // Back-pressure: three triangles with ready_in low.
    do_reset();
    ready_in = 1'b0;
    send_t(20, 1'b0, 1'b1);
    check("bp_ready_after1", 128'(ready_out), 128'(1));
    step();
    send_t(21, 1'b0, 1'b1);
    check("bp_ready_after2", 128'(ready_out), 128'(1));
    step();
    send_t(22, 1'b0, 1'b1);
    check("bp_ready_after3", 128'(ready_out), 128'(0));
    for (int i = 0; i < 4; i++) begin
      check("bp_hold_vertex", vertex_out, tv(20, 0));
      check("bp_hold_idx", 128'(vertex_idx_out), 128'(0));
      check("bp_hold_valid", 128'(valid_out), 128'(1));
      step();
    end
    ready_in = 1'b1;
    wait_drain(30);
    check("bp_ready_restored", 128'(ready_out), 128'(1));

    // Forced push into a full FIFO: the 5th triangle must be dropped.
    do_reset();
    ready_in = 1'b0;
    for (int t = 30; t < 34; t++) send_t(t, 1'b0, 1'b1);
    send_t(34, 1'b0, 1'b0);
    check("ovf_flag", 128'(overflow_err), 128'(CHK));
    check("ovf_tri_count", 128'(tri_count_out), 128'(4));
    ready_in = 1'b1;
    wait_drain(40);
    check("ovf_flag_sticky", 128'(overflow_err), 128'(CHK));

    // Object closed after five triangles: wrong facet count.
    do_reset();
    for (int t = 40; t < 45; t++) begin
      send_t(t, (t == 44), 1'b1);
      repeat (3) step();
    end
    wait_drain(20);
    check("cnt_err_flag", 128'(count_err), 128'(CHK));
    check("cnt_err_tri_count", 128'(tri_count_out), 128'(0));
    check("cnt_err_no_ovf", 128'(overflow_err), 128'(0));

    // Reset mid-triangle: partially emitted triangle is discarded.
    do_reset();
    send_t(50, 1'b0, 1'b1);
    step();
    check("mid_idx1", 128'(vertex_idx_out), 128'(1));
    rst_in = 1'b1;
    #1;
    check("mid_rst_valid", 128'(valid_out), 128'(0));
    check("mid_rst_ready", 128'(ready_out), 128'(1));
    check("mid_rst_idx", 128'(vertex_idx_out), 128'(0));
    check("mid_rst_vertex", vertex_out, 128'(0));
    sb.delete();
    repeat (2) step();
    rst_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("mid_no_stale", 128'(valid_out), 128'(0));
    end

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
